dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipelined core's load/store port and a debug/loader port. Also decodes two memory-mapped registers: an 8-bit LED output register and a free-running 32-bit cycle counter. Sits between the core, the data memory and the top-level outputs. The core is stalled whenever it loses arbitration.

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the core load/store
//            port and a debug/loader port. Also decodes two memory-mapped
//            registers: an 8-bit LED register and a free-running 32-bit
//            cycle counter.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            cpu_*             - core access (combinational read data, stall)
//            dbg_*             - debug access (held request, registered read
//                                data, one-cycle ack pulse)
//            mem_*             - data memory (asynchronous read)
//            led               - LED register contents
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter logic [31:0] LED_ADDR = 32'hFFFF_FF00,
  parameter logic [31:0] CNT_ADDR = 32'hFFFF_FF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  led
);

  typedef enum logic [0:0] {
    D_IDLE = 1'b0,
    D_ACK  = 1'b1
  } dstate_t;

  dstate_t     r_state;
  dstate_t     w_state_nxt;

  logic        r_ptr_dbg;     // priority pointer: 0 = CPU wins contention, 1 = DBG
  logic [7:0]  r_led;
  logic [31:0] r_cnt;
  logic [31:0] r_dbg_rdata;

  logic        w_dbg_elig;
  logic        w_both;
  logic        w_grant_cpu;
  logic        w_grant_dbg;
  logic        w_grant_any;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_is_led;
  logic        w_is_cnt;
  logic [31:0] w_rd_val;
  logic        w_led_wr;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // The debug side is blocked while its ack is outstanding so a request that
  // is still held during the ack cycle cannot be granted (and written) twice.
  assign w_dbg_elig  = dbg_req & (r_state == D_IDLE);
  assign w_both      = cpu_req & w_dbg_elig;
  assign w_grant_cpu = cpu_req & (~w_dbg_elig | ~r_ptr_dbg);
  assign w_grant_dbg = w_dbg_elig & (~cpu_req | r_ptr_dbg);
  assign w_grant_any = w_grant_cpu | w_grant_dbg;

  // With no grant the CPU fields are presented, so selecting on the debug
  // grant alone covers both the granted and the idle case.
  assign w_sel_we    = w_grant_dbg ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_grant_dbg ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_grant_dbg ? dbg_wdata : cpu_wdata;

  // --------------------------------------------------------------------------
  // Address decode (word granularity)
  // --------------------------------------------------------------------------
  assign w_is_led = (w_sel_addr[31:2] == LED_ADDR[31:2]);
  assign w_is_cnt = (w_sel_addr[31:2] == CNT_ADDR[31:2]);

  always_comb begin
    w_rd_val = mem_rdata;
    if (w_is_led) begin
      w_rd_val = {24'b0, r_led};
    end else if (w_is_cnt) begin
      w_rd_val = r_cnt;
    end
  end

  assign w_led_wr = w_grant_any & w_sel_we & w_is_led;

  assign mem_we    = w_grant_any & w_sel_we & ~w_is_led & ~w_is_cnt;
  assign mem_addr  = w_sel_addr;
  assign mem_wdata = w_sel_wdata;

  assign cpu_rdata = w_grant_cpu ? w_rd_val : 32'b0;
  assign cpu_stall = cpu_req & ~w_grant_cpu;

  assign dbg_rdata = r_dbg_rdata;
  assign led       = r_led;

  // --------------------------------------------------------------------------
  // Debug FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dbg_ack     = 1'b0;
    case (r_state)
      D_IDLE: begin
        if (w_grant_dbg) begin
          w_state_nxt = D_ACK;
        end
      end
      D_ACK: begin
        // Gated by reset so an ack that is being aborted never shows.
        dbg_ack     = ~reset;
        w_state_nxt = D_IDLE;
      end
      default: begin
        w_state_nxt = D_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr_dbg   <= 1'b0;
      r_led       <= 8'b0;
      r_cnt       <= 32'b0;
      r_dbg_rdata <= 32'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      // Only contended grants move the pointer.
      if (w_both) begin
        r_ptr_dbg <= ~r_ptr_dbg;
      end
      if (w_led_wr) begin
        r_led <= w_sel_wdata[7:0];
      end
      if (w_grant_dbg && !dbg_we) begin
        r_dbg_rdata <= w_rd_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter. Inputs change on
//            the falling edge; combinational outputs are sampled 1 time unit
//            later, registered outputs one falling edge after their update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam logic [31:0] C_LED = 32'hFFFF_FF00;
  localparam logic [31:0] C_CNT = 32'hFFFF_FF04;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  led;

  int total = 0;
  int bad   = 0;

  logic [31:0] tmem [0:255];
  logic [31:0] v1;
  logic [31:0] v2;

  dmem_arbiter #(
    .LED_ADDR(C_LED),
    .CNT_ADDR(C_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small data memory with asynchronous read.
  assign mem_rdata = tmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) tmem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cpu_set(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dbg_set(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
    dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
    reset = 1'b1;
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    nxt(); nxt(); nxt();

    // ---------------- reset state + counter starts at zero ----------------
    reset = 1'b0;
    cpu_set(1'b1, 1'b0, C_CNT, 32'h0);
    #1;
    chk("rst_led",       {24'b0, led}, 32'h0);
    chk("rst_ack",       {31'b0, dbg_ack}, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("cnt_first",     cpu_rdata, 32'h0);

    // ---------------- 1. CPU only ----------------
    nxt();
    cpu_set(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    #1;
    chk("cpu_wr_mem_we", {31'b0, mem_we}, 32'h1);
    chk("cpu_wr_addr",   mem_addr, 32'h40);
    chk("cpu_wr_stall",  {31'b0, cpu_stall}, 32'h0);
    nxt();
    cpu_set(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("cpu_rd_data",   cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_stall",  {31'b0, cpu_stall}, 32'h0);
    chk("cpu_rd_mem_we", {31'b0, mem_we}, 32'h0);

    // ---------------- 2. Debug only ----------------
    nxt();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b1, 1'b1, 32'h80, 32'h12345678);
    #1;
    chk("dbg_wr_mem_we", {31'b0, mem_we}, 32'h1);
    chk("dbg_wr_addr",   mem_addr, 32'h80);
    chk("dbg_wr_noack",  {31'b0, dbg_ack}, 32'h0);
    nxt();
    #1;
    chk("dbg_wr_ack",    {31'b0, dbg_ack}, 32'h1);
    chk("dbg_held_nowr", {31'b0, mem_we}, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    #1;
    chk("dbg_ack_1cyc",  {31'b0, dbg_ack}, 32'h0);
    dbg_set(1'b1, 1'b0, 32'h80, 32'h0);
    nxt();
    #1;
    chk("dbg_rd_ack",    {31'b0, dbg_ack}, 32'h1);
    chk("dbg_rd_data",   dbg_rdata, 32'h12345678);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- 4. MMIO LED (low address bits ignored) ----------------
    nxt();
    cpu_set(1'b1, 1'b1, C_LED | 32'h3, 32'hFFFF_FFA5);
    #1;
    chk("led_wr_mem_we", {31'b0, mem_we}, 32'h0);
    nxt();
    cpu_set(1'b1, 1'b0, C_LED, 32'h0);
    #1;
    chk("led_val",       {24'b0, led}, 32'h000000A5);
    chk("led_rd",        cpu_rdata, 32'h000000A5);
    nxt();
    // Same-cycle write and read: read returns old value.
    cpu_set(1'b1, 1'b1, C_LED, 32'h0000003C);
    #1;
    chk("led_wr_old_rd", cpu_rdata, 32'h000000A5);
    nxt();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("led_new",       {24'b0, led}, 32'h0000003C);

    // ---------------- 5. Counter ----------------
    nxt();
    cpu_set(1'b1, 1'b0, C_CNT, 32'h0);
    #1;
    v1 = cpu_rdata;
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) nxt();
    cpu_set(1'b1, 1'b0, C_CNT | 32'h2, 32'h0);
    #1;
    v2 = cpu_rdata;
    chk("cnt_delta10",   v2 - v1, 32'd10);
    nxt();
    cpu_set(1'b1, 1'b1, C_CNT, 32'h0);
    #1;
    chk("cnt_wr_mem_we", {31'b0, mem_we}, 32'h0);
    nxt();
    cpu_set(1'b1, 1'b0, C_CNT, 32'h0);
    #1;
    chk("cnt_wr_ignored", cpu_rdata - v2, 32'd2);

    // ---------------- 3. Contention from reset ----------------
    nxt();
    reset = 1'b1;
    cpu_set(1'b1, 1'b0, 32'h40, 32'h0);
    dbg_set(1'b1, 1'b0, 32'h80, 32'h0);
    nxt();
    reset = 1'b0;
    #1;
    // Pointer at CPU: CPU wins, pointer moves to DBG.
    chk("ct1_stall",     {31'b0, cpu_stall}, 32'h0);
    chk("ct1_addr",      mem_addr, 32'h40);
    chk("ct1_rdata",     cpu_rdata, 32'hDEADBEEF);
    nxt();
    #1;
    chk("ct2_stall",     {31'b0, cpu_stall}, 32'h1);
    chk("ct2_addr",      mem_addr, 32'h80);
    chk("ct2_rdata",     cpu_rdata, 32'h0);
    nxt();
    #1;
    // Ack cycle: debug ineligible, CPU granted uncontended (pointer stays CPU).
    chk("ct3_stall",     {31'b0, cpu_stall}, 32'h0);
    chk("ct3_ack",       {31'b0, dbg_ack}, 32'h1);
    chk("ct3_dbg_rdata", dbg_rdata, 32'h12345678);
    nxt();
    #1;
    // Contention with pointer at CPU again: CPU first, then DBG.
    chk("ct4_stall",     {31'b0, cpu_stall}, 32'h0);
    chk("ct4_ack",       {31'b0, dbg_ack}, 32'h0);
    nxt();
    #1;
    chk("ct5_stall",     {31'b0, cpu_stall}, 32'h1);
    chk("ct5_addr",      mem_addr, 32'h80);
    nxt();
    #1;
    chk("ct6_ack",       {31'b0, dbg_ack}, 32'h1);
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- 6. Reset during D_ACK ----------------
    nxt();
    dbg_set(1'b1, 1'b1, C_LED, 32'h00000077);
    #1;
    chk("r6_grant_memwe", {31'b0, mem_we}, 32'h0);
    nxt();
    reset = 1'b1;
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("r6_no_ack",     {31'b0, dbg_ack}, 32'h0);
    nxt();
    // Debug LED write whose grant edge coincides with reset.
    dbg_set(1'b1, 1'b1, C_LED, 32'h00000055);
    nxt();
    reset = 1'b0;
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("r6_led_zero",   {24'b0, led}, 32'h0);
    chk("r6_no_ack2",    {31'b0, dbg_ack}, 32'h0);
    nxt();
    cpu_set(1'b1, 1'b0, 32'h40, 32'h0);
    dbg_set(1'b1, 1'b0, 32'h80, 32'h0);
    #1;
    chk("r6_cpu_first",  {31'b0, cpu_stall}, 32'h0);
    chk("r6_cpu_addr",   mem_addr, 32'h40);
    nxt();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
